// File: rtl/mcu_target_arbiter.sv
// MCU-to-target byte arbiter: routes framed MCU bytes to one of four target ports,
// serves local version/interrupt/mask commands and merges target interrupts.
module mcu_target_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_in_strobe,
    input  logic        data_in_start,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        irq,
    output logic [3:0]  tgt_strobe,
    output logic        tgt_start,
    output logic [7:0]  tgt_data,
    input  logic [31:0] tgt_dout,
    input  logic [3:0]  tgt_irq,
    output logic [3:0]  tgt_iack
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_FWD     = 3'd2,
        ST_LOCAL   = 3'd3,
        ST_DISCARD = 3'd4
    } state_t;

    localparam logic [7:0] CMD_VERSION    = 8'h00;
    localparam logic [7:0] CMD_IRQ_READ   = 8'h01;
    localparam logic [7:0] CMD_MASK_WRITE = 8'h02;
    localparam logic [7:0] VERSION_ID     = 8'h01;
    localparam logic [7:0] MAX_ID         = 8'h04;

    state_t     state_r, state_s;
    logic [2:0] id_r, id_s;
    logic [7:0] cmd_r, cmd_s;
    logic       payload_seen_r, payload_seen_s;
    logic [3:0] irq_mask_r, irq_mask_s;
    logic [1:0] last_grant_r, last_grant_s;
    logic       iack_pend_r, iack_pend_s;
    logic [7:0] data_out_s, tgt_data_s;
    logic [3:0] tgt_strobe_s, tgt_iack_s;
    logic       tgt_start_s, irq_s;
    logic       start_s, body_s, port_sel_s;
    logic [1:0] sel_s;
    logic [2:0] pick_s;
    logic [7:0] port_byte_s;

    // Round-robin pick: nearest requester after 'last', wrapping 3 -> 0; MSB flags a hit.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = last + i[1:0];
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state, datapath and output decode for one MCU byte per cycle.
    always_comb begin
        start_s        = data_in_strobe & data_in_start;
        body_s         = data_in_strobe & ~data_in_start;
        port_sel_s     = (id_r != 3'd0);
        sel_s          = id_r[1:0] - 2'd1;
        port_byte_s    = tgt_dout[{sel_s, 3'b000} +: 8];
        pick_s         = rr_pick(tgt_irq & irq_mask_r, last_grant_r);
        state_s        = state_r;
        id_s           = id_r;
        cmd_s          = cmd_r;
        payload_seen_s = payload_seen_r;
        irq_mask_s     = irq_mask_r;
        last_grant_s   = last_grant_r;
        iack_pend_s    = iack_pend_r;
        data_out_s     = data_out;
        tgt_data_s     = tgt_data;
        tgt_strobe_s   = 4'b0000;
        tgt_start_s    = 1'b0;
        tgt_iack_s     = 4'b0000;
        irq_s          = |(tgt_irq & irq_mask_r);

        case (state_r)
            ST_IDLE: begin
                state_s = ST_IDLE;
            end
            ST_CMD: begin
                if (port_sel_s) begin
                    data_out_s = port_byte_s;
                    if (body_s) begin
                        state_s      = ST_FWD;
                        tgt_strobe_s = 4'b0001 << sel_s;
                        tgt_start_s  = 1'b1;
                        tgt_data_s   = data_in;
                    end else begin
                        state_s = ST_CMD;
                    end
                end else if (body_s) begin
                    state_s        = ST_LOCAL;
                    cmd_s          = data_in;
                    payload_seen_s = 1'b0;
                    case (data_in)
                        CMD_VERSION: data_out_s = VERSION_ID;
                        CMD_IRQ_READ: begin
                            if (pick_s[2]) begin
                                data_out_s   = {1'b1, 5'b00000, pick_s[1:0]};
                                last_grant_s = pick_s[1:0];
                                iack_pend_s  = 1'b1;
                            end else begin
                                data_out_s = 8'h00;
                            end
                        end
                        CMD_MASK_WRITE: data_out_s = data_out;
                        default: data_out_s = 8'h00;
                    endcase
                end else begin
                    state_s = ST_CMD;
                end
            end
            ST_FWD: begin
                data_out_s = port_byte_s;
                if (body_s) begin
                    tgt_strobe_s = 4'b0001 << sel_s;
                    tgt_data_s   = data_in;
                end else begin
                    tgt_strobe_s = 4'b0000;
                end
            end
            ST_LOCAL: begin
                if (body_s) begin
                    payload_seen_s = 1'b1;
                    if (iack_pend_r) begin
                        tgt_iack_s  = 4'b0001 << last_grant_r;
                        iack_pend_s = 1'b0;
                    end else begin
                        tgt_iack_s = 4'b0000;
                    end
                    // Only the first payload byte of a mask write is taken.
                    if ((cmd_r == CMD_MASK_WRITE) && !payload_seen_r) begin
                        irq_mask_s = data_in[3:0];
                    end else begin
                        irq_mask_s = irq_mask_r;
                    end
                end else begin
                    state_s = ST_LOCAL;
                end
            end
            ST_DISCARD: begin
                data_out_s = 8'h00;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // A frame start overrides whatever the current frame was doing.
        if (start_s) begin
            id_s        = data_in[2:0];
            iack_pend_s = 1'b0;
            if (data_in <= MAX_ID) begin
                state_s = ST_CMD;
            end else begin
                state_s = ST_DISCARD;
            end
        end else begin
            id_s = id_s;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            id_r           <= 3'd0;
            cmd_r          <= 8'h00;
            payload_seen_r <= 1'b0;
            irq_mask_r     <= 4'hF;
            last_grant_r   <= 2'd3;
            iack_pend_r    <= 1'b0;
            data_out       <= 8'h00;
            irq            <= 1'b0;
            tgt_strobe     <= 4'b0000;
            tgt_start      <= 1'b0;
            tgt_data       <= 8'h00;
            tgt_iack       <= 4'b0000;
        end else begin
            state_r        <= state_s;
            id_r           <= id_s;
            cmd_r          <= cmd_s;
            payload_seen_r <= payload_seen_s;
            irq_mask_r     <= irq_mask_s;
            last_grant_r   <= last_grant_s;
            iack_pend_r    <= iack_pend_s;
            data_out       <= data_out_s;
            irq            <= irq_s;
            tgt_strobe     <= tgt_strobe_s;
            tgt_start      <= tgt_start_s;
            tgt_data       <= tgt_data_s;
            tgt_iack       <= tgt_iack_s;
        end
    end

endmodule

// File: tb/tb_mcu_target_arbiter.sv
// Scoreboard bench for mcu_target_arbiter: a frame-level reference model queues
// expected target strobes and acks; a negedge monitor pops and compares them.
module tb_mcu_target_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_in_strobe;
    logic        data_in_start;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        irq;
    logic [3:0]  tgt_strobe;
    logic        tgt_start;
    logic [7:0]  tgt_data;
    logic [31:0] tgt_dout;
    logic [3:0]  tgt_irq;
    logic [3:0]  tgt_iack;

    always #5 clk = ~clk;

    mcu_target_arbiter dut (
        .clk(clk), .reset(reset),
        .data_in_strobe(data_in_strobe), .data_in_start(data_in_start), .data_in(data_in),
        .data_out(data_out), .irq(irq),
        .tgt_strobe(tgt_strobe), .tgt_start(tgt_start), .tgt_data(tgt_data),
        .tgt_dout(tgt_dout), .tgt_irq(tgt_irq), .tgt_iack(tgt_iack)
    );

    typedef struct packed {
        logic [3:0] strobe;
        logic       start;
        logic [7:0] data;
    } fwd_t;

    fwd_t       fwd_q[$];
    logic [3:0] iack_q[$];
    int checks = 0;
    int errors = 0;

    typedef enum int {K_NONE, K_LOCAL, K_PORT, K_DISCARD} kind_t;
    kind_t      m_kind;
    int         m_port;
    int         m_nbytes;
    logic [7:0] m_cmd;
    logic [3:0] m_mask;
    int         m_last;
    logic       m_pend;
    int         m_pend_port;
    logic [7:0] m_dout;
    logic       rnd_env;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_kind   = K_NONE;
        m_port   = 0;
        m_nbytes = 0;
        m_cmd    = 8'h00;
        m_mask   = 4'hF;
        m_last   = 3;
        m_pend   = 1'b0;
        m_pend_port = 0;
        m_dout   = 8'h00;
    endtask

    // Frame-level behaviour of one MCU byte, using the current target inputs.
    task automatic model_apply(input logic start, input logic [7:0] data);
        fwd_t       e;
        logic [3:0] req;
        int         g;
        if (m_kind == K_PORT) m_dout = tgt_dout[m_port*8 +: 8];
        if (start) begin
            m_pend   = 1'b0;
            m_nbytes = 0;
            if (data == 8'd0) m_kind = K_LOCAL;
            else if (data <= 8'd4) begin
                m_kind = K_PORT;
                m_port = int'(data) - 1;
            end else m_kind = K_DISCARD;
        end else begin
            case (m_kind)
                K_PORT: begin
                    e.strobe = 4'(1 << m_port);
                    e.start  = (m_nbytes == 0);
                    e.data   = data;
                    fwd_q.push_back(e);
                    m_nbytes++;
                end
                K_LOCAL: begin
                    if (m_nbytes == 0) begin
                        m_cmd = data;
                        if (data == 8'h00) m_dout = 8'h01;
                        else if (data == 8'h01) begin
                            req = tgt_irq & m_mask;
                            g = -1;
                            for (int k = 1; k <= 4; k++) begin
                                if (g < 0 && req[(m_last + k) % 4]) g = (m_last + k) % 4;
                            end
                            if (g >= 0) begin
                                m_dout = 8'h80 | 8'(g);
                                m_last = g;
                                m_pend = 1'b1;
                                m_pend_port = g;
                            end else m_dout = 8'h00;
                        end else if (data != 8'h02) m_dout = 8'h00;
                    end else begin
                        if (m_pend) begin
                            iack_q.push_back(4'(1 << m_pend_port));
                            m_pend = 1'b0;
                        end
                        if (m_cmd == 8'h02 && m_nbytes == 1) m_mask = data[3:0];
                    end
                    m_nbytes++;
                end
                default: m_nbytes = m_nbytes;
            endcase
        end
        if (m_kind == K_PORT) m_dout = tgt_dout[m_port*8 +: 8];
        if (m_kind == K_DISCARD) m_dout = 8'h00;
    endtask

    task automatic send(input logic start, input logic [7:0] data, input int gap);
        @(negedge clk);
        if (rnd_env) begin
            if ($urandom_range(0, 2) == 0) tgt_irq = 4'($urandom);
            if ($urandom_range(0, 2) == 0) tgt_dout = $urandom;
        end
        data_in_strobe = 1'b1;
        data_in_start  = start;
        data_in        = data;
        model_apply(start, data);
        @(negedge clk);
        data_in_strobe = 1'b0;
        data_in_start  = 1'b0;
        data_in        = 8'($urandom);
        repeat (gap) @(negedge clk);
        chk("data_out", 32'(data_out), 32'(m_dout));
        chk("irq", 32'(irq), 32'(|(tgt_irq & m_mask)));
        chk("fwd_missing", 32'(fwd_q.size()), 32'd0);
        chk("iack_missing", 32'(iack_q.size()), 32'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_data_out"}, 32'(data_out), 32'd0);
        chk({tag, "_irq"}, 32'(irq), 32'd0);
        chk({tag, "_tgt_strobe"}, 32'(tgt_strobe), 32'd0);
        chk({tag, "_tgt_start"}, 32'(tgt_start), 32'd0);
        chk({tag, "_tgt_data"}, 32'(tgt_data), 32'd0);
        chk({tag, "_tgt_iack"}, 32'(tgt_iack), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        data_in_strobe = 1'b0;
        data_in_start  = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;
        model_reset();
        fwd_q.delete();
        iack_q.delete();
    endtask

    // Monitor: every target strobe or ack must match the next queued expectation.
    always @(negedge clk) begin
        fwd_t       e;
        logic [3:0] ea;
        if (!reset) begin
            if (tgt_strobe != 4'b0000) begin
                if (fwd_q.size() == 0) chk("tgt_strobe_unexpected", 32'(tgt_strobe), 32'd0);
                else begin
                    e = fwd_q.pop_front();
                    chk("tgt_strobe", 32'(tgt_strobe), 32'(e.strobe));
                    chk("tgt_start", 32'(tgt_start), 32'(e.start));
                    chk("tgt_data", 32'(tgt_data), 32'(e.data));
                end
            end else if (tgt_start) chk("tgt_start_alone", 32'(tgt_start), 32'd0);
            if (tgt_iack != 4'b0000) begin
                if (iack_q.size() == 0) chk("tgt_iack_unexpected", 32'(tgt_iack), 32'd0);
                else begin
                    ea = iack_q.pop_front();
                    chk("tgt_iack", 32'(tgt_iack), 32'(ea));
                end
            end
        end
    end

    logic [7:0] irq_read_exp [3];

    initial begin
        reset = 1'b1;
        data_in_strobe = 1'b0;
        data_in_start  = 1'b0;
        data_in  = 8'h00;
        tgt_dout = 32'h44332211;
        tgt_irq  = 4'b0000;
        rnd_env  = 1'b0;
        model_reset();
        do_reset();

        // Forward a frame to port 1 (id 2).
        send(1'b1, 8'h02, 1);
        send(1'b0, 8'h01, 1);
        send(1'b0, 8'h9F, 1);
        chk("fwd_data_out", 32'(data_out), 32'h22);

        // Three IRQ_READ frames with ports 1 and 3 requesting.
        tgt_irq = 4'b1010;
        irq_read_exp[0] = 8'h81;
        irq_read_exp[1] = 8'h83;
        irq_read_exp[2] = 8'h81;
        for (int f = 0; f < 3; f++) begin
            send(1'b1, 8'h00, 1);
            send(1'b0, 8'h01, 1);
            chk("irq_read_value", 32'(data_out), 32'(irq_read_exp[f]));
            send(1'b0, 8'hA5, 1);
        end

        // Mask only port 1 while port 0 requests.
        tgt_irq = 4'b0001;
        send(1'b1, 8'h00, 1);
        send(1'b0, 8'h02, 1);
        send(1'b0, 8'h02, 1);
        chk("masked_irq", 32'(irq), 32'd0);
        send(1'b0, 8'h0F, 1);
        send(1'b1, 8'h00, 1);
        send(1'b0, 8'h01, 1);
        chk("masked_irq_read", 32'(data_out), 32'd0);
        send(1'b0, 8'h00, 1);
        send(1'b1, 8'h00, 1);
        send(1'b0, 8'h02, 1);
        send(1'b0, 8'h0F, 1);
        chk("unmasked_irq", 32'(irq), 32'd1);

        // Version, unknown command and an invalid target id.
        send(1'b1, 8'h00, 1);
        send(1'b0, 8'h00, 1);
        chk("version", 32'(data_out), 32'h01);
        send(1'b1, 8'h07, 1);
        for (int p = 0; p < 3; p++) send(1'b0, 8'(8'h30 + p), 1);
        chk("discard_data_out", 32'(data_out), 32'd0);

        // Abort a port-2 frame with a new frame to port 0.
        send(1'b1, 8'h03, 1);
        send(1'b0, 8'h10, 1);
        send(1'b0, 8'h20, 1);
        send(1'b1, 8'h01, 1);
        send(1'b0, 8'h30, 1);

        // Reset mid-frame, then a stray payload byte.
        tgt_irq = 4'b0000;
        send(1'b1, 8'h02, 1);
        send(1'b0, 8'h05, 1);
        do_reset();
        send(1'b0, 8'h55, 1);
        chk_idle_outputs("post_reset");

        // Randomised traffic.
        rnd_env = 1'b1;
        for (int n = 0; n < 600; n++) begin
            logic       st;
            logic [7:0] d;
            int         r;
            st = ($urandom_range(0, 4) == 0);
            if (st) begin
                r = $urandom_range(0, 9);
                if (r < 3) d = 8'h00;
                else if (r < 8) d = 8'($urandom_range(1, 4));
                else d = 8'($urandom_range(5, 255));
            end else if (m_kind == K_LOCAL && m_nbytes == 0) begin
                d = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 2));
            end else d = 8'($urandom);
            if ($urandom_range(0, 99) == 0) do_reset();
            send(st, d, $urandom_range(1, 3));
        end

        repeat (3) @(negedge clk);
        chk("final_fwd_queue", 32'(fwd_q.size()), 32'd0);
        chk("final_iack_queue", 32'(iack_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcu_target_arbiter.md
MCU_TARGET_ARBITER -- requirements
Module: mcu_target_arbiter

Interface
REQ-001 clk  in  1  system clock; all logic on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 data_in_strobe  in  1  one-cycle pulse: MCU byte valid on data_in.
REQ-004 data_in_start  in  1  qualifies a strobe as the first byte of a frame.
REQ-005 data_in  in  8  MCU byte.
REQ-006 data_out  out  8  registered byte returned to MCU.
REQ-007 irq  out  1  combined interrupt to MCU.
REQ-008 tgt_strobe  out  4  per-target byte strobe, one-hot or zero.
REQ-009 tgt_start  out  1  qualifies tgt_strobe as the target's command byte.
REQ-010 tgt_data  out  8  byte forwarded to targets.
REQ-011 tgt_dout  in  32  target return bytes, port n on bits [8n+7:8n].
REQ-012 tgt_irq  in  4  level interrupt requests from targets.
REQ-013 tgt_iack  out  4  one-cycle interrupt acknowledge per target.

Function
REQ-014 Frame: byte 0 (strobe with start) = target id; byte 1 = command; bytes 2+ = payload.
REQ-015 Id 0 = local arbiter commands; ids 1-4 = ports 0-3; any other id = discard frame.
REQ-016 FSM states: IDLE, CMD, FWD, LOCAL, DISCARD.
REQ-017 Strobe with start in any state: latch id, go to CMD (id 0-4) or DISCARD; this aborts any frame in progress.
REQ-018 Strobe without start: IDLE and DISCARD ignore it; CMD goes to FWD (port id) or LOCAL (id 0); FWD and LOCAL stay.
REQ-019 Forwarding latency is 1 cycle: tgt_strobe[sel] and tgt_data are registered copies of data_in_strobe and data_in.
REQ-020 tgt_start is 1 only with the forwarded command byte (CMD to FWD transition), else 0.
REQ-021 The id byte is never forwarded. No tgt_strobe in IDLE, LOCAL or DISCARD.
REQ-022 In CMD/FWD with a port selected, data_out <= tgt_dout[sel] every cycle; elsewhere data_out holds, except as in REQ-024..027.
REQ-023 In DISCARD, data_out <= 0x00.
REQ-024 Local cmd 0x00 VERSION: data_out <= 0x01 on the command strobe.
REQ-025 Local cmd 0x01 IRQ_READ, on the command strobe: grant = round-robin pick from (tgt_irq & irq_mask), searching from port last_grant+1 upward with wrap 3 to 0; data_out <= {1'b1,5'b0,2'bgrant}; last_grant <= grant; iack_pend <= 1.
REQ-026 IRQ_READ with nothing pending: data_out <= 0x00; last_grant unchanged; no iack.
REQ-027 On the first payload strobe after IRQ_READ with iack_pend set: tgt_iack[grant] pulses 1 cycle and iack_pend clears. A new frame start clears iack_pend without iack.
REQ-028 Local cmd 0x02 MASK_WRITE: first payload byte [3:0] -> irq_mask; later payload bytes ignored.
REQ-029 Unknown local cmd: payload ignored, data_out <= 0x00.
REQ-030 irq = |(tgt_irq & irq_mask), registered, 1-cycle latency; a mask change takes effect the cycle after the write.
REQ-031 tgt_iack pulses even if the target's irq has dropped meanwhile; at most one tgt_iack bit is high per cycle.

Reset
REQ-032 Reset: state IDLE, data_out 0x00, irq 0, tgt_strobe 0, tgt_start 0, tgt_data 0x00, tgt_iack 0, irq_mask 4'hF, last_grant 3, iack_pend 0.
REQ-033 Reset mid-frame abandons the frame; post-reset non-start strobes are ignored until a start arrives.

Verification
REQ-034 Frame 0x02(start),0x01,0x9F → tgt_strobe=0010 on the cycle after each of the last two strobes; tgt_start=1 only with tgt_data 0x01; second tgt_data 0x9F.
REQ-035 tgt_irq=1010, mask F, three IRQ_READ frames (0x00,0x01,dummy) → data_out 0x81, 0x83, 0x81; tgt_iack pulses 0010, 1000, 0010.
REQ-036 MASK_WRITE payload 0x02 with tgt_irq=0001 → irq 0 from the cycle after the write; IRQ_READ returns 0x00 and gives no iack.
REQ-037 Start byte 0x07, then 3 payload strobes → no tgt_strobe; data_out 0x00.
REQ-038 Start 0x01 mid-FWD on port 2 → port 2 gets no further strobes; next non-start byte goes to port 0 with tgt_start=1.
REQ-039 Reset asserted mid-frame, then a non-start strobe → no tgt_strobe; all outputs at REQ-032 values.
